aemb2_xsl_ctrl: RTL

- Next-generation accelerator (XSL/FSL) bus master for the AEMB2 pipeline.
- Issues one Wishbone transaction per GET/PUT instruction across a parametrised number of channels.
- Supports blocking and non-blocking variants (nGET/nPUT), with a bounded timeout, a carry result flag and a control-tag mismatch error.
- Sits between the operand-fetch stage and the XSL bus; feeds captured data and the pipeline-enable feedback back to the core.

---
 rtl/aemb2_xsl_ctrl_if.sv | 25 ++
 rtl/aemb2_xsl_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/aemb2_xsl_ctrl_if.sv
// XSL/FSL Wishbone bus bundle between the AEMB2 accelerator master and its slaves.
interface aemb2_xsl_ctrl_if #(
  parameter int AEMB_XWB = 7
) ();
  logic [AEMB_XWB-1:2] xwb_adr_o;
  logic [31:0]         xwb_dat_o;
  logic [3:0]          xwb_sel_o;
  logic                xwb_tag_o;
  logic                xwb_wre_o;
  logic                xwb_stb_o;
  logic                xwb_cyc_o;
  logic [31:0]         xwb_dat_i;
  logic                xwb_tag_i;
  logic                xwb_ack_i;

  modport master (
    output xwb_adr_o, xwb_dat_o, xwb_sel_o, xwb_tag_o, xwb_wre_o, xwb_stb_o, xwb_cyc_o,
    input  xwb_dat_i, xwb_tag_i, xwb_ack_i
  );

  modport slave (
    input  xwb_adr_o, xwb_dat_o, xwb_sel_o, xwb_tag_o, xwb_wre_o, xwb_stb_o, xwb_cyc_o,
    output xwb_dat_i, xwb_tag_i, xwb_ack_i
  );
endinterface

// File: rtl/aemb2_xsl_ctrl.sv
// AEMB2 XSL bus master: one Wishbone transaction per GET/PUT, blocking or
// non-blocking with timeout, returning data, carry and tag-error to the core.
module aemb2_xsl_ctrl #(
  parameter int AEMB_XWB = 7,
  parameter int AEMB_TMO = 15,
  parameter int AEMB_TMW = 4
) (
  input  logic                   gclk,
  input  logic                   grst,
  input  logic                   dena,
  input  logic [5:0]             opc_of,
  input  logic [15:0]            imm_of,
  input  logic [31:0]            opa_of,
  aemb2_xsl_ctrl_if.master       xwb,
  output logic                   xwb_fb,
  output logic [31:0]            xwb_mx,
  output logic                   xsl_cry,
  output logic                   xsl_err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [AEMB_TMW-1:0] CNT_TMO  = AEMB_TMW'(AEMB_TMO);
  localparam logic [AEMB_TMW-1:0] CNT_ZERO = AEMB_TMW'(0);
  localparam logic [AEMB_TMW-1:0] CNT_ONE  = AEMB_TMW'(1);

  state_t r_state;
  state_t w_state_nxt;

  logic [AEMB_XWB-1:2] r_adr;
  logic [31:0]         r_dat;
  logic                r_tag;
  logic                r_wre;
  logic                r_stb;
  logic                r_nblk;
  logic [AEMB_TMW-1:0] r_cnt;
  logic [31:0]         r_mx;
  logic                r_cry;
  logic                r_err;

  logic w_go;
  logic w_fb;
  logic w_busy;
  logic w_ack;
  logic w_tmo;
  logic w_term;
  logic w_unused;

  assign w_busy = (r_state == ST_BUSY);
  assign w_tmo  = r_nblk & (r_cnt == CNT_ZERO);
  assign w_ack  = w_busy & xwb.xwb_ack_i;
  // Ack has priority over a coincident timeout.
  assign w_term = w_busy & (xwb.xwb_ack_i | w_tmo);
  assign w_fb   = ~w_busy | xwb.xwb_ack_i | w_tmo;
  assign w_go   = dena & ~opc_of[5] & opc_of[4] & opc_of[3] & w_fb;

  assign w_unused = ^{opc_of[2:0], imm_of[12:AEMB_XWB-2]};

  always_ff @(posedge gclk) begin
    if (grst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          w_state_nxt = ST_BUSY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (w_term && !w_go) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A new issue on the terminating edge reloads the fields with no idle gap.
  always_ff @(posedge gclk) begin
    if (grst) begin
      r_adr  <= '0;
      r_dat  <= 32'h0000_0000;
      r_tag  <= 1'b0;
      r_wre  <= 1'b0;
      r_stb  <= 1'b0;
      r_nblk <= 1'b0;
      r_cnt  <= CNT_ZERO;
    end else if (w_go) begin
      r_adr  <= imm_of[AEMB_XWB-3:0];
      r_dat  <= opa_of;
      r_tag  <= imm_of[13];
      r_wre  <= imm_of[15];
      r_stb  <= 1'b1;
      r_nblk <= imm_of[14];
      r_cnt  <= CNT_TMO;
    end else if (w_term) begin
      r_stb  <= 1'b0;
    end else if (w_busy && r_nblk && (r_cnt != CNT_ZERO)) begin
      r_cnt  <= r_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge gclk) begin
    if (grst) begin
      r_mx  <= 32'h0000_0000;
      r_cry <= 1'b0;
      r_err <= 1'b0;
    end else if (w_ack) begin
      r_cry <= 1'b0;
      if (!r_wre) begin
        r_mx  <= xwb.xwb_dat_i;
        r_err <= (xwb.xwb_tag_i != r_tag);
      end else begin
        r_err <= 1'b0;
      end
    end else if (w_busy && w_tmo) begin
      r_cry <= 1'b1;
      r_err <= 1'b0;
      if (!r_wre) begin
        r_mx <= 32'h0000_0000;
      end
    end
  end

  assign xwb.xwb_adr_o = r_adr;
  assign xwb.xwb_dat_o = r_dat;
  assign xwb.xwb_sel_o = 4'hF;
  assign xwb.xwb_tag_o = r_tag;
  assign xwb.xwb_wre_o = r_wre;
  assign xwb.xwb_stb_o = r_stb;
  assign xwb.xwb_cyc_o = r_stb;

  assign xwb_fb  = w_fb;
  assign xwb_mx  = r_mx;
  assign xsl_cry = r_cry;
  assign xsl_err = r_err;

endmodule
